keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Behavioural-in-RTL 4x4 keypad: the passive end of the keypad row/column scan interface.
//  Takes keycodes over a valid/ready handshake, then answers the column scan by pulling
//  the matching row low for a programmed hold time, then releases.
//  Used for hardware-in-loop/self-test: COL from the keypad scanner feeds it; its ROW drives the scanner.
// PARAMETERS
//  HOLD_CYCLES    500000  cycles the key contact is held closed (10 ms @ 50 MHz)
//  GAP_CYCLES     500000  cycles of guaranteed release after a press, before the next accept
//  BOUNCE_CYCLES  50000   length of each bounce window (used only with the bounce macro)
//  CNT_W          20      width of the timing counter; must hold max(HOLD,GAP,BOUNCE)-1
// PORTS
//  clock      in   1  system clock
//  reset_n    in   1  asynchronous active-low reset
//  key_code   in   4  {row_idx[3:2], col_idx[1:0]} of the key to press
//  key_valid  in   1  request to press key_code
//  key_ready  out  1  high in IDLE only; transfer happens when key_valid & key_ready
//  col        in   4  scanner column drive, active-low
//  row        out  4  row return to scanner, active-low, idle 4'hF
//  busy       out  1  ~key_ready
//  contact    out  1  current state of the emulated switch (1 = closed)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counter=0, latched code=0, contact=0, row=4'hF,
//   key_ready=1, busy=0. Reset mid-press releases the key immediately; the request is lost.
//  Handshake: key_code latched on the clock edge where key_valid&key_ready; key_ready drops
//   the next cycle. key_valid without key_ready is ignored (no queue); key_code may change freely.
//  row = (contact & ~col[c]) ? ~(4'b0001<<r) : 4'hF, where r,c come from the latched code.
//   Combinational from col (models a passive switch); other col bits are don't-care.
//  FSM (counter reloads to 0 on every state entry; exit when counter==N-1):
//   IDLE -> PRESS_BOUNCE on accept; PRESS_BOUNCE -> HOLD after BOUNCE_CYCLES;
//   HOLD -> REL_BOUNCE after HOLD_CYCLES; REL_BOUNCE -> GAP after BOUNCE_CYCLES;
//   GAP -> IDLE after GAP_CYCLES.
//  contact: HOLD=1; IDLE/GAP=0; bounce states = bounce source (see CONFIGURATION).
//  Latency: contact=1 on the first cycle of HOLD; key_ready returns on the cycle after the
//   final GAP cycle. Total press period = HOLD_CYCLES + GAP_CYCLES (+2*BOUNCE_CYCLES).
//  N=1 for any count parameter is legal (single-cycle state); N=0 is illegal.
//  Counter never wraps: it is compared and reloaded, never free-running.
// CONFIGURATION
//  KEYPAD_EMU_BOUNCE_EN defined: bounce states are present; contact = lfsr[0] of a 16-bit
//   Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reset to seed, advances every cycle
//   while in a bounce state, holds otherwise).
//  Undefined: bounce states and LFSR not built; IDLE -> HOLD and HOLD -> GAP directly;
//   BOUNCE_CYCLES is ignored. The contact waveform is then a single clean pulse.
// STRUCTURE
//  keypad_pkg: state enum {IDLE,PRESS_BOUNCE,HOLD,REL_BOUNCE,GAP}, KEYCODE_W=4,
//   ROW_IDLE=4'hF, LFSR_SEED=16'hACE1, LFSR taps.
//  One sub-module: bounce_lfsr (16-bit, enable, async active-low reset), instantiated only
//   under KEYPAD_EMU_BOUNCE_EN. The FSM, counter and row decode stay in this module.
// TESTING (HOLD=8, GAP=4, BOUNCE=6)
//  1 Reset: after reset_n low, row=4'hF, key_ready=1, contact=0 for any col value.
//  2 Press 4'b0110 (r=1,c=2), macro off: HOLD is exactly 8 cycles; with col=4'b1011,
//    row=4'b1101; with col=4'b1101, row=4'hF; key_ready back after 12 cycles.
//  3 key_valid held high with changing key_code during busy: only the first code is used;
//    the second press starts 1 cycle after key_ready returns.
//  4 Macro on, seed ACE1: contact matches the reference LFSR sequence for 6 cycles, is
//    steady 1 for 8, matches again for 6, then 0; total busy = 24 cycles.
//  5 reset_n asserted mid-HOLD: row=4'hF asynchronously (same cycle); key_ready=1 after release.
//  6 Closed loop with the keypad scanner + debouncer at real params: press 4'hF, 4'h0, 4'h5;
//    the scanner keycode output equals each code, one keystrobe per press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator: FSM states,
// idle row pattern and the bounce LFSR seed/taps.
package keypad_pkg;

  localparam int          KEYCODE_W = 4;
  localparam logic [3:0]  ROW_IDLE  = 4'hF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_BOUNCE = 3'd1,
    HOLD         = 3'd2,
    REL_BOUNCE   = 3'd3,
    GAP          = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key request channel of the keypad emulator.
// Handshake: key_code is transferred on the clock edge where key_valid & key_ready
// are both high; key_valid without key_ready is ignored, busy is always ~key_ready.
interface keypad_emulator_if;
  import keypad_pkg::*;

  logic [KEYCODE_W-1:0] key_code;
  logic                 key_valid;
  logic                 key_ready;
  logic                 busy;

  modport master (output key_code, output key_valid, input key_ready, input busy);
  modport slave  (input key_code, input key_valid, output key_ready, output busy);

endinterface

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR used as the contact-bounce noise source; advances only
// while enabled and restarts from the seed on reset.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_bit = r_lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad: accepts a keycode, then pulls the addressed row low while its
// column is scanned, for a programmed hold time. Define KEYPAD_EMU_BOUNCE_EN for bounce.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 500000,
  parameter int GAP_CYCLES    = 500000,
  parameter int BOUNCE_CYCLES = 50000,
  parameter int CNT_W         = 20
) (
  input  logic               clock,
  input  logic               reset_n,
  keypad_emulator_if.slave   kif,
  input  logic [3:0]         col,
  output logic [3:0]         row,
  output logic               contact,
  output state_t             o_dbg_state
);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("keypad_emulator: cycle counts must be at least 1");
  end

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [KEYCODE_W-1:0] r_code;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_bounce_bit;
  logic [1:0]           w_r;
  logic [1:0]           w_c;

  assign w_accept    = kif.key_valid && (r_state == IDLE);
  assign kif.key_ready = (r_state == IDLE);
  assign kif.busy      = (r_state != IDLE);
  assign o_dbg_state = r_state;

`ifdef KEYPAD_EMU_BOUNCE_EN
  bounce_lfsr u_bounce_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    ((r_state == PRESS_BOUNCE) || (r_state == REL_BOUNCE)),
    .o_bit   (w_bounce_bit)
  );
`else
  assign w_bounce_bit = 1'b0;
`endif

  // Terminal count of the current state; the counter restarts on every state entry.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      HOLD:         w_done = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
      GAP:          w_done = (r_cnt == CNT_W'(GAP_CYCLES - 1));
`ifdef KEYPAD_EMU_BOUNCE_EN
      PRESS_BOUNCE: w_done = (r_cnt == CNT_W'(BOUNCE_CYCLES - 1));
      REL_BOUNCE:   w_done = (r_cnt == CNT_W'(BOUNCE_CYCLES - 1));
`endif
      default:      w_done = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          w_next = PRESS_BOUNCE;
`else
          w_next = HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      PRESS_BOUNCE: if (w_done) w_next = HOLD;
      HOLD:         if (w_done) w_next = REL_BOUNCE;
      REL_BOUNCE:   if (w_done) w_next = GAP;
`else
      HOLD:         if (w_done) w_next = GAP;
`endif
      GAP:          if (w_done) w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_code <= kif.key_code;
      end
    end
  end

  always_comb begin
    contact = 1'b0;
    case (r_state)
      HOLD:         contact = 1'b1;
      PRESS_BOUNCE: contact = w_bounce_bit;
      REL_BOUNCE:   contact = w_bounce_bit;
      default:      contact = 1'b0;
    endcase
  end

  // Passive switch: the row follows the column drive combinationally.
  assign w_r = r_code[3:2];
  assign w_c = r_code[1:0];
  assign row = (contact && !col[w_c]) ? ~(4'b0001 << w_r) : ROW_IDLE;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator with HOLD=8, GAP=4, BOUNCE=6; also covers
// the KEYPAD_EMU_BOUNCE_EN build via a reference LFSR model.
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD   = 8;
  localparam int GAP    = 4;
  localparam int BOUNCE = 6;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int PRE   = BOUNCE;
  localparam int TOTAL = HOLD + GAP + 2 * BOUNCE;
`else
  localparam int PRE   = 0;
  localparam int TOTAL = HOLD + GAP;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] col     = 4'hF;
  logic [3:0] row;
  logic       contact;
  state_t     dbg_state;

  keypad_emulator_if kif();

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .BOUNCE_CYCLES (BOUNCE),
    .CNT_W         (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .kif         (kif),
    .col         (col),
    .row         (row),
    .contact     (contact),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  exp_q[$];        // {last, contact, row}
  logic [15:0] m_lfsr = 16'hACE1;
  bit          want_idle = 1'b0;
  bit          want_busy = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_row(input logic [3:0] code, input logic [3:0] c,
                                         input logic k);
    logic [3:0] r;
    r = 4'hF;
    if (k && !c[code[1:0]]) r[code[3:2]] = 1'b0;
    return r;
  endfunction

  task automatic push_item(input logic [3:0] code, input logic [3:0] c,
                           input logic k, input logic last);
    exp_q.push_back({last, k, exp_row(code, c, k)});
  endtask

  task automatic push_bounce(input logic [3:0] code, input logic [3:0] c);
    for (int i = 0; i < BOUNCE; i++) begin
      push_item(code, c, m_lfsr[0], 1'b0);
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  endtask

  task automatic push_press(input logic [3:0] code, input logic [3:0] c);
`ifdef KEYPAD_EMU_BOUNCE_EN
    push_bounce(code, c);
`endif
    for (int i = 0; i < HOLD; i++) push_item(code, c, 1'b1, 1'b0);
`ifdef KEYPAD_EMU_BOUNCE_EN
    push_bounce(code, c);
`endif
    for (int i = 0; i < GAP; i++) push_item(code, c, 1'b0, i == GAP - 1);
  endtask

  // Monitor: one expected entry per busy cycle, plus press/release length tracking.
  initial begin
    logic [5:0] item;
    forever begin
      @(negedge clock);
      #1;
      if (reset_n) begin
        if (want_idle) begin
          want_idle = 1'b0;
          check("release_len", 16'(kif.busy), 16'd0);
        end else if (want_busy && !kif.busy) begin
          want_busy = 1'b0;
          check("press_len", 16'(kif.busy), 16'd1);
        end
        if (kif.busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy: busy with no expected entry at %0t", $time);
          end else begin
            item = exp_q.pop_front();
            check("contact", 16'(contact), 16'(item[4]));
            check("row", 16'(row), 16'(item[3:0]));
            want_busy = !item[5];
            want_idle = item[5];
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!kif.key_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!kif.key_ready) check(name, 16'(kif.key_ready), 16'd1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clock);
    #1;
    while (kif.busy && n < 100) begin
      n++;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code, input logic [3:0] c);
    int n;
    @(negedge clock);
    wait_ready("ready_timeout");
    col           = c;
    kif.key_code  = code;
    kif.key_valid = 1'b1;
    push_press(code, c);
    @(posedge clock);
    #1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'($urandom_range(15));
    count_busy(n);
    check("busy_cycles", 16'(n), 16'(TOTAL));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] junk [4] = '{4'hF, 4'h1, 4'h3, 4'hC};
  logic [3:0] rst_cols [3] = '{4'h0, 4'hA, 4'hF};

  initial begin
    int n;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;

    // Reset values, independent of column drive.
    #3 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      col = rst_cols[i];
      #1;
      check("rst_row", 16'(row), 16'hF);
      check("rst_ready", 16'(kif.key_ready), 16'd1);
      check("rst_contact", 16'(contact), 16'd0);
    end
    check("rst_busy", 16'(kif.busy), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_state", 16'(dbg_state), 16'(IDLE));

    // Directed presses: scanned column, unscanned column, corner keys.
    press(4'b0110, 4'b1011);
    press(4'b0110, 4'b1101);
    press(4'hF, 4'b0111);
    press(4'h0, 4'b1110);
    press(4'h5, 4'b1101);

    // key_valid held through busy with a changing code.
    @(negedge clock);
    wait_ready("t3_ready");
    col           = 4'b1011;
    kif.key_code  = 4'b0110;
    kif.key_valid = 1'b1;
    push_press(4'b0110, 4'b1011);
    @(posedge clock);
    n = 0;
    @(negedge clock);
    while (!kif.key_ready && n < 100) begin
      kif.key_code = junk[n % 4];
      n++;
      @(negedge clock);
    end
    check("t3_first_len", 16'(n), 16'(TOTAL));
    kif.key_code = 4'b1010;
    push_press(4'b1010, 4'b1011);
    @(posedge clock);
    #1;
    kif.key_valid = 1'b0;
    count_busy(n);
    check("t3_second_len", 16'(n), 16'(TOTAL));

    // Asynchronous reset in the middle of HOLD.
    @(negedge clock);
    wait_ready("t5_ready");
    col           = 4'b1011;
    kif.key_code  = 4'b0110;
    kif.key_valid = 1'b1;
    push_press(4'b0110, 4'b1011);
    @(posedge clock);
    #1;
    kif.key_valid = 1'b0;
    repeat (PRE + 3) @(posedge clock);
    #2;
    check("t5_hold_row", 16'(row), 16'hD);
    reset_n = 1'b0;
    #1;
    check("t5_rst_row", 16'(row), 16'hF);
    check("t5_rst_contact", 16'(contact), 16'd0);
    check("t5_rst_ready", 16'(kif.key_ready), 16'd1);
    exp_q.delete();
    want_idle = 1'b0;
    want_busy = 1'b0;
    m_lfsr    = 16'hACE1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("t5_ready_after", 16'(kif.key_ready), 16'd1);
    check("t5_state_after", 16'(dbg_state), 16'(IDLE));

    // Recovery press after the reset.
    press(4'h9, 4'b1101);

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
